// File: rtl/hs_rx.sv
// hs_rx: receive side of a 4-phase req/ack handshake crossing into the clk domain.
//
// The sender holds din stable, raises req, waits for ack, drops req, waits for ack to fall.
// req is synchronized through SYNC_STAGES flops; din is captured unsynchronized while
// req_s=1 and ack=0, which is safe because the sender holds it for the whole phase.
// The captured word is offered downstream on dout/dval and is acknowledged to the sender
// only once drdy accepts it.
//
// Ports:
//   clk   in   receive-domain clock, rising edge
//   rst   in   synchronous active-high reset
//   req   in   4-phase request, asynchronous to clk
//   din   in   [DWIDTH-1:0] sender data
//   ack   out  4-phase acknowledge, registered
//   dout  out  [DWIDTH-1:0] captured word, registered
//   dval  out  dout valid, registered
//   drdy  in   downstream ready
//   err   out  one-cycle pulse when req drops before the word is accepted
//   busy  out  high whenever a transfer is in progress
//   cnt   out  [CWIDTH-1:0] words accepted downstream, wraps silently

module hs_rx #(
    parameter int unsigned DWIDTH      = 8,
    parameter int unsigned SYNC_STAGES = 2,   // legal 2..4
    parameter int unsigned CWIDTH      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [DWIDTH-1:0] din,
    output logic              ack,
    output logic [DWIDTH-1:0] dout,
    output logic              dval,
    input  logic              drdy,
    output logic              err,
    output logic              busy,
    output logic [CWIDTH-1:0] cnt
);

    typedef enum logic [1:0] {StIdle, StCapt, StAck} state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;

    state_e              state_q, state_d;
    logic                ack_q, ack_d;
    logic                dval_q, dval_d;
    logic [DWIDTH-1:0]   dout_q, dout_d;
    logic                err_q, err_d;
    logic                viol_q, viol_d;  // violation already flagged this transfer
    logic [CWIDTH-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        dval_d  = dval_q;
        dout_d  = dout_q;
        err_d   = 1'b0;
        viol_d  = viol_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                viol_d = 1'b0;
                if (req_s) begin
                    dout_d  = din;
                    dval_d  = 1'b1;
                    state_d = StCapt;
                end
            end
            StCapt: begin
                // Sender withdrew req before we acknowledged: flag once, still deliver.
                if (!req_s && !viol_q) begin
                    err_d  = 1'b1;
                    viol_d = 1'b1;
                end
                // Acceptance is taken regardless of req_s.
                if (dval_q && drdy) begin
                    dval_d  = 1'b0;
                    ack_d   = 1'b1;
                    cnt_d   = cnt_q + CWIDTH'(1);
                    state_d = StAck;
                end
            end
            StAck: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ack_q   <= 1'b0;
            dval_q  <= 1'b0;
            dout_q  <= '0;
            err_q   <= 1'b0;
            viol_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            dval_q  <= dval_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            viol_q  <= viol_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ack  = ack_q;
    assign dval = dval_q;
    assign dout = dout_q;
    assign err  = err_q;
    assign cnt  = cnt_q;
    // Masked by rst so busy reads 0 throughout a reset cycle, even before the edge.
    assign busy = (state_q != StIdle) && !rst;

endmodule

// File: tb/tb_hs_rx.sv
// Directed bench for hs_rx. Expected words go into a scoreboard queue when driven and are
// popped by a monitor when the DUT offers a word that drdy accepts. A second instance with
// CWIDTH=2 shares all inputs to exercise counter wrap.

module tb_hs_rx;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [7:0] din;
    logic       drdy;

    logic       ack, dval, err, busy;
    logic [7:0] dout;
    logic [15:0] cnt;

    logic       ack_w, dval_w, err_w, busy_w;
    logic [7:0] dout_w;
    logic [1:0] cnt_w;

    int checks = 0;
    int failures = 0;
    int err_pulses = 0;
    int accepted = 0;
    int exp_cnt = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    hs_rx #(.DWIDTH(8), .SYNC_STAGES(SYNC), .CWIDTH(16)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .ack(ack), .dout(dout),
        .dval(dval), .drdy(drdy), .err(err), .busy(busy), .cnt(cnt)
    );

    hs_rx #(.DWIDTH(8), .SYNC_STAGES(SYNC), .CWIDTH(2)) dut_w (
        .clk(clk), .rst(rst), .req(req), .din(din), .ack(ack_w), .dout(dout_w),
        .dval(dval_w), .drdy(drdy), .err(err_w), .busy(busy_w), .cnt(cnt_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after each rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: sample midway through the cycle; dval&drdy means the word is taken next edge.
    always @(negedge clk) begin
        if (!rst && err) err_pulses++;
        if (!rst && dval && drdy) begin
            accepted++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $error("FAIL sb_unexpected observed=%0h expected=none", dout);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                assert (dout === e) else begin
                    failures++;
                    $error("FAIL sb_word observed=%0h expected=%0h", dout, e);
                end
            end
        end
    end

    // One full handshake starting from IDLE with req low; gap = cycles of drdy=0 after dval.
    task automatic transfer(input logic [7:0] d, input int gap);
        int n;
        din  = d;
        drdy = (gap == 0);
        req  = 1'b1;
        sb.push_back(d);
        exp_cnt++;
        n = 0;
        while (!dval && n < 20) begin tick(); n++; end
        check("cap_latency", n, SYNC + 1);
        check("cap_dout", dout, d);
        check("cap_busy", busy, 1);
        for (int i = 0; i < gap; i++) begin
            tick();
            check("bp_dval", dval, 1);
            check("bp_ack", ack, 0);
            check("bp_dout", dout, d);
        end
        drdy = 1'b1;
        n = 0;
        while (!ack && n < 20) begin tick(); n++; end
        check("ack_latency", n, 1);
        check("acc_dval_low", dval, 0);
        check("acc_cnt", cnt, exp_cnt[15:0]);
        req = 1'b0;
        n = 0;
        while (ack && n < 20) begin tick(); n++; end
        check("ackfall_latency", n, SYNC + 1);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        int n;
        int e0;
        logic [1:0] wrap_exp [5];
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        rst = 1'b1; req = 1'b0; din = 8'h00; drdy = 1'b0;
        tick(); tick();
        check("rst_ack", ack, 0);
        check("rst_dval", dval, 0);
        check("rst_dout", dout, 0);
        check("rst_err", err, 0);
        check("rst_cnt", cnt, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        // Basic transfer, drdy held high: one-cycle dval, ack after 4 edges, fall after 3.
        transfer(8'hA5, 0);
        check("basic_err", err_pulses, 0);

        // Backpressure for 10 cycles.
        transfer(8'h3C, 10);

        // Protocol violation: req dropped while dval=1 and drdy=0.
        din = 8'h5A; drdy = 1'b0; req = 1'b1;
        sb.push_back(8'h5A);
        exp_cnt++;
        n = 0;
        while (!dval && n < 20) begin tick(); n++; end
        check("viol_cap", dval, 1);
        req = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("viol_err_once", err_pulses, 1);
        check("viol_dval_held", dval, 1);
        check("viol_ack_low", ack, 0);
        drdy = 1'b1;
        n = 0;
        while (!ack && n < 20) begin tick(); n++; end
        check("viol_ack_rise", n, 1);
        tick();
        check("viol_ack_fall", ack, 0);
        check("viol_cnt", cnt, exp_cnt[15:0]);
        check("viol_busy", busy, 0);
        check("viol_err_total", err_pulses, 1);

        // Back-to-back with random backpressure gaps.
        e0 = accepted;
        for (int k = 1; k <= 4; k++) transfer(8'(k), int'($urandom_range(0, 3)));
        check("b2b_words", accepted - e0, 4);
        check("b2b_err", err_pulses, 1);

        // Reset while in ACK with req still high.
        din = 8'h77; drdy = 1'b1; req = 1'b1;
        sb.push_back(8'h77);
        n = 0;
        while (!ack && n < 20) begin tick(); n++; end
        check("mid_in_ack", ack, 1);
        rst = 1'b1;
        #1;
        check("mid_busy_in_rst", busy, 0);
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        check("mid_ack", ack, 0);
        check("mid_dval", dval, 0);
        check("mid_cnt", cnt, 0);
        check("mid_busy", busy, 0);
        sb.push_back(8'h77);
        exp_cnt++;
        n = 0;
        while (!dval && n < 20) begin tick(); n++; end
        check("mid_recap_latency", n, SYNC + 1);
        n = 0;
        while (!ack && n < 20) begin tick(); n++; end
        check("mid_ack_again", ack, 1);
        check("mid_cnt_after", cnt, 1);
        req = 1'b0;
        n = 0;
        while (ack && n < 20) begin tick(); n++; end
        check("mid_ack_fall", n, SYNC + 1);

        // Counter wrap on the CWIDTH=2 instance.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        exp_cnt = 0;
        check("wrap_start", cnt_w, 0);
        for (int k = 0; k < 5; k++) begin
            transfer(8'(8'h10 + k), 0);
            check("wrap_cnt", cnt_w, wrap_exp[k]);
        end

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
